ref_wb_drain_tracker: RTL and testbench

- Tracks completion of reference-particle force writeback across all PEs for one reference ID.
- Then decides when the force interconnect has drained.
- Supersedes the fixed NUM_CELLS-cycle drain counter with a selectable fixed-count or credit-based drain, a hold-until-release handshake, a timeout, and error flags.
- Sits between the PE array, the ring interconnect and the broadcast controller. Its outputs gate motion-update start and the advance to the next reference particle.

---
 rtl/ref_wb_drain_tracker.sv | 204 ++++++++++++++++++++
 tb/tb_ref_wb_drain_tracker.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_wb_drain_tracker.sv
// Reference-particle writeback completion and interconnect drain tracker.
// Gates motion-update start and the advance to the next reference particle.
module ref_wb_drain_tracker #(
    parameter int NUM_CELLS      = 64,
    parameter int DRAIN_MODE     = 1,
    parameter int DRAIN_CYCLES   = 64,
    parameter int MAX_INFLIGHT   = 1024,
    parameter int QUIET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CELLS-1:0] ref_wb_issued,
    input  logic [NUM_CELLS-1:0] inj_valid,
    input  logic [NUM_CELLS-1:0] ej_valid,
    input  logic                 goto_next_ref,
    input  logic                 abort,
    output logic                 all_ref_wb_issued,
    output logic                 interconnect_empty,
    output logic [CNT_WIDTH-1:0] inflight_count,
    output logic [1:0]           state_out,
    output logic                 err_underflow,
    output logic                 err_overflow,
    output logic                 err_timeout
);

    localparam int PW = $clog2(NUM_CELLS + 1);
    localparam int SW = CNT_WIDTH + $clog2(NUM_CELLS) + 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_INFLIGHT);
    localparam logic [CNT_WIDTH-1:0] MAX_V = CNT_WIDTH'(MAX_INFLIGHT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EMPTY   = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_CELLS-1:0]   sticky_q;
    logic [NUM_CELLS-1:0]   sticky_d;
    logic [DW-1:0]          drain_q;
    logic [DW-1:0]          drain_d;
    logic [QW-1:0]          quiet_q;
    logic [QW-1:0]          quiet_d;
    logic [TW-1:0]          tmo_q;
    logic [TW-1:0]          tmo_d;
    logic                   tmo_set;
    logic                   normal_exit;
    logic                   tmo_hit;
    logic [NUM_CELLS-1:0]   merged;

    logic [PW-1:0]          inj_pop;
    logic [PW-1:0]          ej_pop;
    logic signed [SW-1:0]   sum;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   uf_set;
    logic                   of_set;

    function automatic logic [PW-1:0] popcnt(input logic [NUM_CELLS-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Credit arithmetic: widen, add injections, subtract ejections, clamp.
    always_comb begin
        inj_pop = popcnt(inj_valid);
        ej_pop  = popcnt(ej_valid);
        sum     = $signed({{(SW-CNT_WIDTH){1'b0}}, inflight_count})
                + $signed({{(SW-PW){1'b0}}, inj_pop})
                - $signed({{(SW-PW){1'b0}}, ej_pop});
        cnt_d   = sum[CNT_WIDTH-1:0];
        uf_set  = 1'b0;
        of_set  = 1'b0;
        if (sum < 0) begin
            cnt_d  = '0;
            uf_set = 1'b1;
        end else if (sum > MAX_S) begin
            cnt_d  = MAX_V;
            of_set = 1'b1;
        end
    end

    // Credit counter and sticky error flags, independent of the round FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_count <= '0;
            err_underflow  <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            inflight_count <= cnt_d;
            err_underflow  <= err_underflow | uf_set;
            err_overflow   <= err_overflow | of_set;
        end
    end

    // Round FSM next state: collect pulses, drain, hold empty until release.
    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        drain_d  = drain_q;
        quiet_d  = quiet_q;
        tmo_d    = tmo_q;
        tmo_set  = 1'b0;
        merged   = sticky_q | ref_wb_issued;

        if (DRAIN_MODE == 0) begin
            normal_exit = (drain_q == DRAIN_LAST);
        end else begin
            normal_exit = (inflight_count == '0) && (quiet_q == QUIET_LAST);
        end
        tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

        unique case (state_q)
            COLLECT: begin
                sticky_d = merged;
                if (&merged) begin
                    state_d = DRAIN;
                    drain_d = '0;
                    quiet_d = '0;
                    tmo_d   = '0;
                end
            end
            DRAIN: begin
                if (DRAIN_MODE == 0) begin
                    drain_d = drain_q + DW'(1);
                end else if (inflight_count == '0) begin
                    quiet_d = quiet_q + QW'(1);
                end else begin
                    quiet_d = '0;
                end
                if (TIMEOUT_CYCLES != 0) begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (goto_next_ref) begin
                    state_d  = COLLECT;
                    sticky_d = '0;
                end else if (normal_exit) begin
                    state_d = EMPTY;
                end else if (tmo_hit) begin
                    state_d = EMPTY;
                    tmo_set = 1'b1;
                end
            end
            EMPTY: begin
                if (goto_next_ref) begin
                    state_d  = COLLECT;
                    sticky_d = ref_wb_issued;
                end
            end
            default: begin
                state_d  = COLLECT;
                sticky_d = '0;
            end
        endcase

        if (abort) begin
            state_d  = COLLECT;
            sticky_d = '0;
            drain_d  = '0;
            quiet_d  = '0;
            tmo_d    = '0;
            tmo_set  = 1'b0;
        end
    end

    // Round FSM registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= COLLECT;
            sticky_q           <= '0;
            drain_q            <= '0;
            quiet_q            <= '0;
            tmo_q              <= '0;
            all_ref_wb_issued  <= 1'b0;
            interconnect_empty <= 1'b0;
            err_timeout        <= 1'b0;
        end else begin
            state_q            <= state_d;
            sticky_q           <= sticky_d;
            drain_q            <= drain_d;
            quiet_q            <= quiet_d;
            tmo_q              <= tmo_d;
            all_ref_wb_issued  <= (state_d != COLLECT);
            interconnect_empty <= (state_d == EMPTY);
            err_timeout        <= err_timeout | tmo_set;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_ref_wb_drain_tracker.sv
// Bench for ref_wb_drain_tracker: fixed-drain and credit-drain instances
// driven in parallel, checked by tables, hand sequences and a reference model.
module tb_ref_wb_drain_tracker;

    localparam int N    = 4;
    localparam int MAXI = 15;
    localparam int DC   = 4;
    localparam int QC   = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] iss;
    logic [N-1:0] inj;
    logic [N-1:0] ej;
    logic goto_r;
    logic ab;

    logic all0, emp0, uf0, of0, to0;
    logic all1, emp1, uf1, of1, to1;
    logic [3:0] cnt0, cnt1;
    logic [1:0] st0, st1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int mode_p [2] = '{0, 1};
    int tmo_p  [2] = '{0, 8};

    int     m_state  [2];
    bit [3:0] m_sticky [2];
    int     m_entry  [2];
    int     m_zrun   [2];
    int     m_cnt    [2];
    bit     m_uf     [2];
    bit     m_of     [2];
    bit     m_to     [2];

    typedef struct {
        logic [3:0] iss;
        logic       go;
        int         es;
        int         ea;
        int         ee;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    ref_wb_drain_tracker #(
        .NUM_CELLS(N), .DRAIN_MODE(0), .DRAIN_CYCLES(DC),
        .MAX_INFLIGHT(MAXI), .QUIET_CYCLES(QC),
        .TIMEOUT_CYCLES(0), .CNT_WIDTH(4)
    ) u_fix (
        .clk(clk), .rst(rst), .ref_wb_issued(iss),
        .inj_valid(inj), .ej_valid(ej),
        .goto_next_ref(goto_r), .abort(ab),
        .all_ref_wb_issued(all0), .interconnect_empty(emp0),
        .inflight_count(cnt0), .state_out(st0),
        .err_underflow(uf0), .err_overflow(of0), .err_timeout(to0)
    );

    ref_wb_drain_tracker #(
        .NUM_CELLS(N), .DRAIN_MODE(1), .DRAIN_CYCLES(DC),
        .MAX_INFLIGHT(MAXI), .QUIET_CYCLES(QC),
        .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)
    ) u_crd (
        .clk(clk), .rst(rst), .ref_wb_issued(iss),
        .inj_valid(inj), .ej_valid(ej),
        .goto_next_ref(goto_r), .abort(ab),
        .all_ref_wb_issued(all1), .interconnect_empty(emp1),
        .inflight_count(cnt1), .state_out(st1),
        .err_underflow(uf1), .err_overflow(of1), .err_timeout(to1)
    );

    task automatic xchk(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d]  = 0;
            m_sticky[d] = '0;
            m_entry[d]  = 0;
            m_zrun[d]   = 0;
            m_cnt[d]    = 0;
            m_uf[d]     = 0;
            m_of[d]     = 0;
            m_to[d]     = 0;
        end
    endtask

    // Rules applied to one cycle of inputs; yields the next cycle's view.
    task automatic model_step(input bit [3:0] i_iss, input bit [3:0] i_inj,
                              input bit [3:0] i_ej, input bit i_go,
                              input bit i_ab);
        for (int d = 0; d < 2; d++) begin
            int c;
            int ns;
            int el;
            bit [3:0] nsk;
            c = m_cnt[d] + $countones(i_inj) - $countones(i_ej);
            if (c < 0) begin
                c = 0;
                m_uf[d] = 1;
            end else if (c > MAXI) begin
                c = MAXI;
                m_of[d] = 1;
            end
            ns  = m_state[d];
            nsk = m_sticky[d];
            el  = cyc - m_entry[d];
            if (i_ab) begin
                ns  = 0;
                nsk = '0;
            end else if (m_state[d] == 0) begin
                nsk = nsk | i_iss;
                if (nsk == 4'hF) begin
                    ns = 1;
                    m_entry[d] = cyc + 1;
                    m_zrun[d] = 0;
                end
            end else if (m_state[d] == 1) begin
                m_zrun[d] = (m_cnt[d] == 0) ? m_zrun[d] + 1 : 0;
                if (i_go) begin
                    ns  = 0;
                    nsk = '0;
                end else if (mode_p[d] == 0 ? (el + 1 >= DC)
                                            : (m_zrun[d] >= QC)) begin
                    ns = 2;
                end else if (tmo_p[d] != 0 && el + 1 >= tmo_p[d]) begin
                    ns = 2;
                    m_to[d] = 1;
                end
            end else begin
                if (i_go) begin
                    ns  = 0;
                    nsk = i_iss;
                end
            end
            m_cnt[d]    = c;
            m_state[d]  = ns;
            m_sticky[d] = nsk;
        end
    endtask

    task automatic model_cmp();
        for (int d = 0; d < 2; d++) begin
            logic [1:0] a_st;
            logic a_all, a_emp, a_uf, a_of, a_to;
            logic [3:0] a_cnt;
            if (d == 0) begin
                a_st = st0; a_all = all0; a_emp = emp0;
                a_uf = uf0; a_of = of0; a_to = to0; a_cnt = cnt0;
            end else begin
                a_st = st1; a_all = all1; a_emp = emp1;
                a_uf = uf1; a_of = of1; a_to = to1; a_cnt = cnt1;
            end
            xchk($sformatf("model_state%0d", d), 32'(a_st), m_state[d]);
            xchk($sformatf("model_allref%0d", d), 32'(a_all),
                 32'(m_state[d] != 0));
            xchk($sformatf("model_empty%0d", d), 32'(a_emp),
                 32'(m_state[d] == 2));
            xchk($sformatf("model_count%0d", d), 32'(a_cnt), m_cnt[d]);
            xchk($sformatf("model_uflow%0d", d), 32'(a_uf), 32'(m_uf[d]));
            xchk($sformatf("model_oflow%0d", d), 32'(a_of), 32'(m_of[d]));
            xchk($sformatf("model_tmo%0d", d), 32'(a_to), 32'(m_to[d]));
        end
    endtask

    task automatic tick(input logic [3:0] i_iss, input logic [3:0] i_inj,
                        input logic [3:0] i_ej, input logic i_go,
                        input logic i_ab);
        iss    = i_iss;
        inj    = i_inj;
        ej     = i_ej;
        goto_r = i_go;
        ab     = i_ab;
        model_step(i_iss, i_inj, i_ej, i_go, i_ab);
        @(posedge clk);
        #1;
        cyc++;
        model_cmp();
    endtask

    task automatic chk_zero(input string nm);
        xchk({nm, "_st0"}, 32'(st0), 0);
        xchk({nm, "_all0"}, 32'(all0), 0);
        xchk({nm, "_emp0"}, 32'(emp0), 0);
        xchk({nm, "_cnt0"}, 32'(cnt0), 0);
        xchk({nm, "_err0"}, 32'({uf0, of0, to0}), 0);
        xchk({nm, "_st1"}, 32'(st1), 0);
        xchk({nm, "_all1"}, 32'(all1), 0);
        xchk({nm, "_emp1"}, 32'(emp1), 0);
        xchk({nm, "_cnt1"}, 32'(cnt1), 0);
        xchk({nm, "_err1"}, 32'({uf1, of1, to1}), 0);
    endtask

    initial begin
        logic [3:0] c_inj [11];
        logic [3:0] c_ej  [11];
        logic [3:0] c_iss [11];
        int         c_cnt [11];

        // Fixed-drain round: {ref pulses, release, expected next-cycle view}
        tbl[0]  = '{4'b0000, 1'b0, 0, 0, 0};
        tbl[1]  = '{4'b0001, 1'b0, 0, 0, 0};
        tbl[2]  = '{4'b0010, 1'b0, 0, 0, 0};
        tbl[3]  = '{4'b0100, 1'b0, 0, 0, 0};
        tbl[4]  = '{4'b0000, 1'b0, 0, 0, 0};
        tbl[5]  = '{4'b0000, 1'b0, 0, 0, 0};
        tbl[6]  = '{4'b1000, 1'b0, 1, 1, 0};
        tbl[7]  = '{4'b0000, 1'b0, 1, 1, 0};
        tbl[8]  = '{4'b0000, 1'b0, 1, 1, 0};
        tbl[9]  = '{4'b0000, 1'b0, 1, 1, 0};
        tbl[10] = '{4'b0000, 1'b0, 2, 1, 1};
        tbl[11] = '{4'b0000, 1'b0, 2, 1, 1};
        tbl[12] = '{4'b0000, 1'b0, 2, 1, 1};
        tbl[13] = '{4'b0000, 1'b0, 2, 1, 1};
        tbl[14] = '{4'b0000, 1'b1, 0, 0, 0};
        tbl[15] = '{4'b0000, 1'b0, 0, 0, 0};

        c_iss = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        c_inj = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        c_ej  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                  4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
        c_cnt = '{0, 0, 4, 4, 4, 3, 2, 1, 0, 0, 0};

        rst = 1'b1; iss = '0; inj = '0; ej = '0; goto_r = 1'b0; ab = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("reset");
        rst = 1'b0;
        model_reset();
        cyc = 0;

        for (int k = 0; k < 16; k++) begin
            tick(tbl[k].iss, 4'h0, 4'h0, tbl[k].go, 1'b0);
            xchk($sformatf("tbl_state[%0d]", k), 32'(st0), tbl[k].es);
            xchk($sformatf("tbl_allref[%0d]", k), 32'(all0), tbl[k].ea);
            xchk($sformatf("tbl_empty[%0d]", k), 32'(emp0), tbl[k].ee);
        end

        for (int j = 0; j < 11; j++) begin
            tick(c_iss[j], c_inj[j], c_ej[j], 1'b0, 1'b0);
            xchk($sformatf("crd_count[%0d]", j), 32'(cnt1), c_cnt[j]);
            xchk($sformatf("crd_empty[%0d]", j), 32'(emp1), 32'(j == 10));
        end
        xchk("crd_no_timeout", 32'(to1), 0);
        tick(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        xchk("crd_release", 32'(st1), 0);

        tick(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        tick(4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        xchk("sim_count5", 32'(cnt1), 5);
        tick(4'h0, 4'h3, 4'h1, 1'b0, 1'b0);
        xchk("sim_count6", 32'(cnt1), 6);
        tick(4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        tick(4'h0, 4'h0, 4'h3, 1'b0, 1'b0);
        xchk("uf_before", 32'(uf1), 0);
        tick(4'h0, 4'h0, 4'h1, 1'b0, 1'b0);
        xchk("uf_count", 32'(cnt1), 0);
        xchk("uf_flag", 32'(uf1), 1);
        tick(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        xchk("uf_sticky", 32'(uf1), 1);
        tick(4'h0, 4'h0, 4'h1, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) tick(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        xchk("of_count", 32'(cnt1), MAXI);
        xchk("of_flag", 32'(of1), 1);
        for (int k = 0; k < 3; k++) tick(4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        tick(4'h0, 4'h0, 4'h7, 1'b0, 1'b0);
        xchk("of_drained", 32'(cnt1), 0);

        tick(4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        tick(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("tmo_entry", 32'(st1), 1);
        for (int k = 0; k < 7; k++) tick(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("tmo_pre_state", 32'(st1), 1);
        xchk("tmo_pre_flag", 32'(to1), 0);
        tick(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("tmo_state", 32'(st1), 2);
        xchk("tmo_flag", 32'(to1), 1);
        xchk("tmo_count", 32'(cnt1), 1);
        xchk("fix_no_tmo", 32'(to0), 0);

        tick(4'h5, 4'h0, 4'h0, 1'b1, 1'b0);
        xchk("rel_state", 32'(st1), 0);
        tick(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("rel_hold", 32'(st1), 0);
        tick(4'hA, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("rel_redrain", 32'(st1), 1);
        xchk("rel_allref", 32'(all0), 1);

        tick(4'h0, 4'h3, 4'h0, 1'b0, 1'b0);
        xchk("ab_pre_count", 32'(cnt1), 3);
        xchk("ab_pre_state", 32'(st0), 1);
        tick(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        xchk("ab_state", 32'(st1), 0);
        xchk("ab_allref", 32'(all1), 0);
        xchk("ab_count", 32'(cnt1), 3);
        xchk("ab_tmo_kept", 32'(to1), 1);

        tick(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        xchk("early_rel", 32'(st0), 0);
        tick(4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("early_cleared", 32'(st1), 0);

        for (int k = 0; k < 400; k++) begin
            logic [3:0] r_iss, r_inj, r_ej;
            r_iss = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            r_inj = 4'($urandom) & 4'($urandom);
            r_ej  = 4'($urandom) & 4'($urandom);
            tick(r_iss, r_inj, r_ej,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        tick(4'h0, 4'h3, 4'h0, 1'b0, 1'b1);
        tick(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        xchk("rst_pre_state", 32'(st1), 1);
        rst = 1'b1; iss = '0; inj = '0; ej = '0; goto_r = 1'b0; ab = 1'b0;
        @(posedge clk); #1;
        cyc++;
        chk_zero("mid_rst");
        rst = 1'b0;
        model_reset();
        tick(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
